dct_transpose_buf: RTL and testbench



---
 rtl/dct_transpose_buf.sv | 97 +++++++++
 tb/tb_dct_transpose_buf.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dct_transpose_buf.sv
// 8x8 transpose buffer between the row DCT pass and DCT_second: rows in, columns out.
// Define DCT_TRANSPOSE_PINGPONG_EN for two banks (full rate); otherwise a single bank.
module dct_transpose_buf #(
    parameter int DATA_W = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [8*DATA_W-1:0] in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [8*DATA_W-1:0] out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2:0]          count1,
    output logic                out_last
);

`ifdef DCT_TRANSPOSE_PINGPONG_EN
    localparam logic BANK_TOGGLE = 1'b1;
`else
    localparam logic BANK_TOGGLE = 1'b0;
`endif
    localparam int VW = 8 * DATA_W;

    // Indexed [bank][row][col]; bank 1 is never addressed in the single-bank build.
    logic [DATA_W-1:0] r_mem [2][8][8];

    logic [1:0] r_full;
    logic [1:0] w_full_nxt;
    logic       r_wr_bank;
    logic       r_rd_bank;
    logic [2:0] r_wr_row;
    logic [2:0] r_rd_col;
    logic       w_wr_acc;
    logic       w_rd_acc;

    assign w_wr_acc = in_valid && in_ready;
    assign w_rd_acc = out_valid && out_ready;

    always_comb begin
        in_ready  = !r_full[r_wr_bank];
        out_valid = r_full[r_rd_bank];
        count1    = r_rd_col;
        out_last  = (r_rd_col == 3'd7);
    end

    // Write and read never hit the same bank in one cycle, so both updates apply.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_acc && (r_wr_row == 3'd7)) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_acc && (r_rd_col == 3'd7)) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_wr_row  <= 3'd0;
            r_rd_bank <= 1'b0;
            r_rd_col  <= 3'd0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_acc) begin
                r_wr_row <= r_wr_row + 3'd1;
                if (r_wr_row == 3'd7) begin
                    r_wr_bank <= r_wr_bank ^ BANK_TOGGLE;
                end
            end
            if (w_rd_acc) begin
                r_rd_col <= r_rd_col + 3'd1;
                if (r_rd_col == 3'd7) begin
                    r_rd_bank <= r_rd_bank ^ BANK_TOGGLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int c = 0; c < 8; c++) begin
                r_mem[r_wr_bank][r_wr_row][c] <= in[VW-1-c*DATA_W -: DATA_W];
            end
        end
    end

    always_comb begin
        out = '0;
        for (int r = 0; r < 8; r++) begin
            out[VW-1-r*DATA_W -: DATA_W] = r_mem[r_rd_bank][r][r_rd_col];
        end
    end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Directed bench for dct_transpose_buf; adapts to DCT_TRANSPOSE_PINGPONG_EN.
module tb_dct_transpose_buf;
    localparam int DW = 9;
    localparam int VW = 8 * DW;
`ifdef DCT_TRANSPOSE_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [VW-1:0] in;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] out;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    count1;
    logic          out_last;

    int n_chk  = 0;
    int n_fail = 0;

    dct_transpose_buf #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .count1(count1), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Pattern 8: signed extremes -256/+255 alternating; others: p*64 + 8r + c.
    function automatic logic [DW-1:0] elem(input int p, input int r, input int c);
        logic [DW-1:0] v;
        if (p == 8) v = (((r + c) % 2) == 1) ? 9'h0FF : 9'h100;
        else        v = DW'((p * 64 + 8 * r + c) & 511);
        return v;
    endfunction

    function automatic logic [VW-1:0] mkrow(input int p, input int r);
        logic [VW-1:0] v;
        v = '0;
        for (int c = 0; c < 8; c++) v[VW-1-c*DW -: DW] = elem(p, r, c);
        return v;
    endfunction

    function automatic logic [VW-1:0] mkcol(input int p, input int c);
        logic [VW-1:0] v;
        v = '0;
        for (int r = 0; r < 8; r++) v[VW-1-r*DW -: DW] = elem(p, r, c);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_rows(input int p, input int n, input bit chk_nv);
        for (int r = 0; r < n; r++) begin
            int to;
            in_valid = 1'b1;
            in = mkrow(p, r);
            to = 0;
            while (!in_ready && to < 50) begin
                step();
                to++;
            end
            chk("wr_ready", VW'(in_ready), VW'(1));
            step();
            if (chk_nv && r < 7) chk("no_valid_early", VW'(out_valid), VW'(0));
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int p);
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            chk("drain_valid", VW'(out_valid), VW'(1));
            chk("drain_count1", VW'(count1), VW'(c));
            chk("drain_last", VW'(out_last), VW'(c == 7));
            chk("drain_col", out, mkcol(p, c));
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic stream(input int nblk, input int exp_low, input int exp_cyc, input int exp_gaps);
        int wr_k = 0;
        int rd_k = 0;
        int low = 0;
        int cyc = 0;
        int last_rd = -1;
        int gaps = 0;
        bit wacc;
        bit racc;
        in_valid = 1'b1;
        out_ready = 1'b1;
        in = mkrow(0, 0);
        while (rd_k < nblk * 8 && cyc < 400) begin
            wacc = in_valid && in_ready;
            racc = out_valid && out_ready;
            if (!in_ready) low++;
            if (racc) begin
                chk("stream_col", out, mkcol(rd_k / 8, rd_k % 8));
                chk("stream_count1", VW'(count1), VW'(rd_k % 8));
                chk("stream_last", VW'(out_last), VW'((rd_k % 8) == 7));
                if (last_rd >= 0 && cyc != last_rd + 1) gaps++;
                last_rd = cyc;
            end
            step();
            cyc++;
            if (wacc) begin
                wr_k++;
                if (wr_k < nblk * 8) in = mkrow(wr_k / 8, wr_k % 8);
                else in_valid = 1'b0;
            end
            if (racc) rd_k++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("stream_cols_done", VW'(rd_k), VW'(nblk * 8));
        chk("stream_cycles", VW'(cyc), VW'(exp_cyc));
        chk("stream_in_ready_low", VW'(low), VW'(exp_low));
        chk("stream_col_gaps", VW'(gaps), VW'(exp_gaps));
    endtask

    initial begin
        rst = 1'b1;
        in = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", VW'(in_ready), VW'(1));
        chk("rst_out_valid", VW'(out_valid), VW'(0));
        chk("rst_count1", VW'(count1), VW'(0));
        chk("rst_out_last", VW'(out_last), VW'(0));
        rst = 1'b0;
        step();

        // Basic transpose: column 0 must be visible right after the row-7 edge.
        write_rows(0, 8, 1'b0);
        chk("basic_valid", VW'(out_valid), VW'(1));
        chk("basic_count1", VW'(count1), VW'(0));
        chk("basic_col0", out, mkcol(0, 0));
        chk("basic_in_ready", VW'(in_ready), VW'(NB == 2));
        drain(0);
        chk("basic_done_valid", VW'(out_valid), VW'(0));
        chk("basic_done_in_ready", VW'(in_ready), VW'(1));

        // Backpressure: fill every bank with out_ready low, hold, then drain in order.
        write_rows(1, 8, 1'b0);
        if (NB == 2) write_rows(2, 8, 1'b0);
        in_valid = 1'b1;
        in = mkrow(7, 0);
        for (int i = 0; i < 4; i++) begin
            chk("bp_in_ready", VW'(in_ready), VW'(0));
            chk("bp_hold_col", out, mkcol(1, 0));
            chk("bp_hold_count1", VW'(count1), VW'(0));
            chk("bp_hold_valid", VW'(out_valid), VW'(1));
            step();
        end
        in_valid = 1'b0;
        drain(1);
        if (NB == 2) drain(2);
        chk("bp_done_valid", VW'(out_valid), VW'(0));

        // Signed extremes pass through bit-exact.
        write_rows(8, 8, 1'b0);
        drain(8);

        // Reset mid-block discards the partial block.
        write_rows(6, 5, 1'b0);
        rst = 1'b1;
        #2;
        chk("mid_rst_valid", VW'(out_valid), VW'(0));
        chk("mid_rst_in_ready", VW'(in_ready), VW'(1));
        chk("mid_rst_count1", VW'(count1), VW'(0));
        step();
        rst = 1'b0;
        step();
        write_rows(5, 8, 1'b1);
        chk("mid_rst_new_valid", VW'(out_valid), VW'(1));
        drain(5);

        // Continuous streaming.
        if (NB == 2) stream(4, 0, 40, 0);
        else         stream(2, 16, 32, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
